// File: rtl/seq_feed_pkg.sv
// Shared types and constants for the sequence-detector feed controller.
package seq_feed_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultCntW  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFlush,
    StDone
  } state_e;

  // Largest value representable in a cnt_w-bit counter.
  function automatic int unsigned SAT_MAX(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past SAT_MAX(CNT_W).
module sat_counter
  import seq_feed_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SAT_MAX(CNT_W));

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != CntMax)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_feed_controller.sv
// Serialises a pattern word MSB-first onto x and counts Moore/Mealy detector hits.
// Optional end-of-run count comparator enabled by SEQ_FEED_COMPARE_EN.
module seq_feed_controller
  import seq_feed_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW,
  localparam int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             z_moore,
  input  logic             z_mealy,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits_moore,
  output logic [CNT_W-1:0] hits_mealy,
  output logic             mismatch
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [IDX_W-1:0] r_idx;
  logic             r_first;
  logic             r_x;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_len;
  logic [IDX_W-1:0] w_start_idx;
  logic             w_accept;
  logic             w_inc_moore;
  logic             w_inc_mealy;
  logic [CNT_W-1:0] w_hits_moore;
  logic [CNT_W-1:0] w_hits_mealy;

  assign w_len       = (length > LenMax) ? LenMax : length;
  assign w_start_idx = IDX_W'(w_len - LEN_W'(1));
  assign w_accept    = (r_state == StIdle) && start;

  // Moore output lags x by one cycle, so its window is shifted one edge later.
  assign w_inc_mealy = (r_state == StShift) && z_mealy;
  assign w_inc_moore = z_moore && (((r_state == StShift) && !r_first) || (r_state == StFlush));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_pat   <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_len == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StShift;
              r_pat   <= pattern;
              r_idx   <= w_start_idx;
              r_x     <= pattern[w_start_idx];
              r_busy  <= 1'b1;
              r_first <= 1'b1;
            end
          end
        end
        StShift: begin
          r_first <= 1'b0;
          if (r_idx == '0) begin
            r_state <= StFlush;
            r_x     <= 1'b0;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
            r_x   <= r_pat[r_idx - IDX_W'(1)];
          end
        end
        StFlush: begin
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_moore (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept),
    .inc   (w_inc_moore),
    .count (w_hits_moore)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_mealy (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept),
    .inc   (w_inc_mealy),
    .count (w_hits_mealy)
  );

`ifdef SEQ_FEED_COMPARE_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SAT_MAX(CNT_W));

  logic             r_mismatch;
  logic [CNT_W-1:0] w_moore_final;

  // The trailing Moore hit lands on the same edge, so compare its post-edge value.
  assign w_moore_final = (w_inc_moore && (w_hits_moore != CntMax)) ?
                         w_hits_moore + CNT_W'(1) : w_hits_moore;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_mismatch <= 1'b0;
    end else if (r_state == StFlush) begin
      r_mismatch <= (w_moore_final != w_hits_mealy);
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

  assign x          = r_x;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hits_moore = w_hits_moore;
  assign hits_mealy = w_hits_mealy;

endmodule
